// File: rtl/rsa_pkg.sv
// rsa_pkg: shared types, default sizes and result-reduction helper for the
// rsa_tile_engine matrix-multiply tile.
// Optional feature macro: RSA_SAT_EN (saturating reduction instead of wrap).
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DRAIN
  } state_t;

  localparam int unsigned X_DEF          = 3;
  localparam int unsigned N_DEF          = 4;
  localparam int unsigned Y_DEF          = 3;
  localparam int unsigned IN_LEN_DEF     = 4;
  localparam int unsigned OUT_LEN_DEF    = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  // Working width of the reduction helper; any accumulator fits inside it.
  localparam int unsigned RED_W = 64;

  // Reduce a full-width signed sum to out_len bits (result in the low bits,
  // sign-extended to RED_W so the caller can truncate).
  function automatic logic signed [RED_W-1:0] reduce_sat(
    input logic signed [RED_W-1:0] v,
    input int unsigned             out_len
  );
`ifdef RSA_SAT_EN
    logic signed [RED_W-1:0] hi;
    logic signed [RED_W-1:0] lo;
    hi = $signed((RED_W'(1) << (out_len - 1)) - RED_W'(1));
    lo = -hi - $signed(RED_W'(1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (RED_W - out_len)) >>> (RED_W - out_len);
`endif
  endfunction

endpackage

// File: rtl/rsa_tile_engine_mac.sv
// rsa_mac: one signed multiply-accumulate lane.
// Ports: clk, rst (async active-high), en (step this cycle), first (load seed
// instead of running sum), seed (prior C element or 0), a/b operands,
// result_c (accumulator reduced to OUT_LEN, combinational from the register).
module rsa_mac
  import rsa_pkg::*;
#(
  parameter int unsigned IN_LEN  = IN_LEN_DEF,
  parameter int unsigned OUT_LEN = OUT_LEN_DEF,
  parameter int unsigned ACC_W   = 2 * IN_LEN_DEF + 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      first,
  input  logic signed [OUT_LEN-1:0] seed,
  input  logic signed [IN_LEN-1:0]  a,
  input  logic signed [IN_LEN-1:0]  b,
  output logic        [OUT_LEN-1:0] result_c
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    base_c;
  logic signed [2*IN_LEN-1:0] prod_c;

  // Full-precision product; the first k of a row restarts from the seed.
  always_comb begin
    prod_c = a * b;
    base_c = first ? ACC_W'(seed) : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else if (en) acc <= base_c + ACC_W'(prod_c);
  end

  assign result_c = OUT_LEN'(reduce_sat(RED_W'(acc), OUT_LEN));

endmodule

// File: rtl/rsa_tile_engine.sv
// rsa_tile_engine: buffers A (XxN) and B (NxY) from two ready/valid streams,
// computes C = A*B (optionally + previous C) with Y MAC lanes, then streams C
// out row-major.
// Ports: clk, sys_rst (async active-high); Xin_*/Yin_* operand streams;
// SA_start/SA_acc launch; busy/done status; out_val/out_rdy/out_data result.
// Optional feature macro: RSA_SAT_EN (saturate instead of wrap on reduction).
module rsa_tile_engine
  import rsa_pkg::*;
#(
  parameter int unsigned X          = X_DEF,
  parameter int unsigned N          = N_DEF,
  parameter int unsigned Y          = Y_DEF,
  parameter int unsigned IN_LEN     = IN_LEN_DEF,
  parameter int unsigned OUT_LEN    = OUT_LEN_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               Xin_val,
  output logic               Xin_rdy,
  input  logic [IN_LEN-1:0]  Xin_data,
  input  logic               Yin_val,
  output logic               Yin_rdy,
  input  logic [IN_LEN-1:0]  Yin_data,
  input  logic               SA_start,
  input  logic               SA_acc,
  output logic               busy,
  output logic               done,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [OUT_LEN-1:0] out_data
);

  localparam int unsigned A_SZ  = X * N;
  localparam int unsigned B_SZ  = N * Y;
  localparam int unsigned C_SZ  = X * Y;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned ACC_W = 2 * IN_LEN + $clog2(N) + 1;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        x_cnt, y_cnt, x_cnt_d, y_cnt_d;
  logic [ADDR_WIDTH-1:0]   row, k, wr_row, out_idx, a_idx;
  logic                    wr_pend, acc_mode, c_valid;
  logic                    x_push_c, y_push_c, start_c, last_step_c, last_xfer_c;

  logic [IN_LEN-1:0]       a_buf [A_SZ];
  logic [IN_LEN-1:0]       b_buf [B_SZ];
  logic [OUT_LEN-1:0]      c_buf [C_SZ];
  logic [OUT_LEN-1:0]      lane_res [Y];

  // State register.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else state <= state_d;
  end

  // Next state, fill counts and control strobes.
  always_comb begin
    state_d     = state;
    x_cnt_d     = x_cnt;
    y_cnt_d     = y_cnt;
    x_push_c    = 1'b0;
    y_push_c    = 1'b0;
    start_c     = 1'b0;
    last_step_c = 1'b0;
    last_xfer_c = 1'b0;
    case (state)
      IDLE: begin
        x_push_c = Xin_val && Xin_rdy;
        y_push_c = Yin_val && Yin_rdy;
        if (x_push_c) x_cnt_d = x_cnt + 1'b1;
        if (y_push_c) y_cnt_d = y_cnt + 1'b1;
        if (SA_start && x_cnt == CNT_W'(A_SZ) && y_cnt == CNT_W'(B_SZ)) begin
          start_c = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (row == ADDR_WIDTH'(X - 1) && k == ADDR_WIDTH'(N - 1)) begin
          last_step_c = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (out_val && out_rdy && out_idx == ADDR_WIDTH'(C_SZ - 1)) begin
          last_xfer_c = 1'b1;
          state_d     = IDLE;
          x_cnt_d     = '0;
          y_cnt_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, row-write pipeline and registered outputs.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      row      <= '0;
      k        <= '0;
      wr_pend  <= 1'b0;
      wr_row   <= '0;
      acc_mode <= 1'b0;
      c_valid  <= 1'b0;
      out_idx  <= '0;
      Xin_rdy  <= 1'b0;
      Yin_rdy  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_val  <= 1'b0;
      out_data <= '0;
    end else begin
      x_cnt   <= x_cnt_d;
      y_cnt   <= y_cnt_d;
      Xin_rdy <= (state_d == IDLE) && (x_cnt_d < CNT_W'(A_SZ));
      Yin_rdy <= (state_d == IDLE) && (y_cnt_d < CNT_W'(B_SZ));
      busy    <= (state_d != IDLE);

      if (start_c) begin
        row      <= '0;
        k        <= '0;
        acc_mode <= SA_acc;
      end else if (state == COMPUTE) begin
        if (last_step_c) begin
          row <= '0;
          k   <= '0;
        end else if (k == ADDR_WIDTH'(N - 1)) begin
          row <= row + 1'b1;
          k   <= '0;
        end else begin
          k <= k + 1'b1;
        end
      end

      // A row's accumulators are final the cycle after its last k.
      wr_pend <= (state == COMPUTE) && (k == ADDR_WIDTH'(N - 1));
      if (state == COMPUTE) wr_row <= row;
      done <= wr_pend && (wr_row == ADDR_WIDTH'(X - 1));

      if (last_xfer_c) c_valid <= 1'b1;

      // Drain starts the cycle after done; data advances only on a transfer.
      if (done) begin
        out_val  <= 1'b1;
        out_data <= c_buf[0];
        out_idx  <= '0;
      end else if (out_val && out_rdy) begin
        if (out_idx == ADDR_WIDTH'(C_SZ - 1)) begin
          out_val  <= 1'b0;
          out_data <= '0;
        end else begin
          out_idx  <= out_idx + 1'b1;
          out_data <= c_buf[out_idx + 1'b1];
        end
      end
    end
  end

  // Operand and result storage; contents are qualified by counts and c_valid.
  always_ff @(posedge clk) begin
    if (x_push_c) a_buf[x_cnt[ADDR_WIDTH-1:0]] <= Xin_data;
    if (y_push_c) b_buf[y_cnt[ADDR_WIDTH-1:0]] <= Yin_data;
    if (wr_pend) begin
      for (int unsigned j = 0; j < Y; j++) begin
        c_buf[ADDR_WIDTH'(wr_row * Y + j)] <= lane_res[j];
      end
    end
  end

  assign a_idx = ADDR_WIDTH'(row * N + k);

  for (genvar j = 0; j < Y; j++) begin : g_lane
    logic [ADDR_WIDTH-1:0] b_idx;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [OUT_LEN-1:0]    seed;

    assign b_idx = ADDR_WIDTH'(k * Y + j);
    assign c_idx = ADDR_WIDTH'(row * Y + j);
    // Prior C is only trusted after a completed drain with no reset since.
    assign seed  = (acc_mode && c_valid) ? c_buf[c_idx] : '0;

    rsa_mac #(
      .IN_LEN  (IN_LEN),
      .OUT_LEN (OUT_LEN),
      .ACC_W   (ACC_W)
    ) u_mac (
      .clk      (clk),
      .rst      (sys_rst),
      .en       (state == COMPUTE),
      .first    (k == '0),
      .seed     (seed),
      .a        (a_buf[a_idx]),
      .b        (b_buf[b_idx]),
      .result_c (lane_res[j])
    );
  end

endmodule

// File: tb/tb_rsa_tile_engine.sv
// tb_rsa_tile_engine: directed self-checking bench for rsa_tile_engine at
// X=3, N=4, Y=3, IN_LEN=4, OUT_LEN=8.
module tb_rsa_tile_engine;

  localparam int unsigned X = 3, N = 4, Y = 3, IN_LEN = 4, OUT_LEN = 8, ADDR_WIDTH = 4;
  localparam int unsigned A_SZ = X * N, B_SZ = N * Y, C_SZ = X * Y;

  logic               clk = 1'b0;
  logic               sys_rst;
  logic               Xin_val, Yin_val, Xin_rdy, Yin_rdy;
  logic [IN_LEN-1:0]  Xin_data, Yin_data;
  logic               SA_start, SA_acc, busy, done;
  logic               out_val, out_rdy;
  logic [OUT_LEN-1:0] out_data;

  int checks = 0;
  int errors = 0;

  rsa_tile_engine #(
    .X(X), .N(N), .Y(Y), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .Xin_val(Xin_val), .Xin_rdy(Xin_rdy), .Xin_data(Xin_data),
    .Yin_val(Yin_val), .Yin_rdy(Yin_rdy), .Yin_data(Yin_data),
    .SA_start(SA_start), .SA_acc(SA_acc),
    .busy(busy), .done(done),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [IN_LEN-1:0] av[A_SZ], input logic [IN_LEN-1:0] bv[B_SZ],
                      input bit do_a, input bit do_b);
    int xs, ys, n;
    bit xa, ya;
    xs = do_a ? 0 : A_SZ;
    ys = do_b ? 0 : B_SZ;
    n  = 0;
    while ((xs < A_SZ || ys < B_SZ) && n < 100) begin
      Xin_val = (xs < A_SZ);
      Yin_val = (ys < B_SZ);
      if (xs < A_SZ) Xin_data = av[xs];
      if (ys < B_SZ) Yin_data = bv[ys];
      xa = Xin_val && Xin_rdy;
      ya = Yin_val && Yin_rdy;
      @(posedge clk); #1;
      n++;
      if (xa) xs++;
      if (ya) ys++;
    end
    Xin_val = 1'b0;
    Yin_val = 1'b0;
    check("load_count", 32'(xs + ys), 32'(A_SZ + B_SZ));
    if (do_a) check("load_xrdy_full", 32'(Xin_rdy), 32'd0);
    if (do_b) check("load_yrdy_full", 32'(Yin_rdy), 32'd0);
  endtask

  task automatic run(input logic acc, input bit toggle, input logic [OUT_LEN-1:0] exp[C_SZ],
                     input string tag);
    int n, got, cyc, dn;
    bit stalled;
    logic [OUT_LEN-1:0] held;
    SA_acc   = acc;
    SA_start = 1'b1;
    @(posedge clk); #1;
    SA_start = 1'b0;
    SA_acc   = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n  = 0;
    dn = 0;
    while (!out_val && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) dn++;
    end
    check({tag, "_latency"}, 32'(n), 32'(X * N + 2));
    got     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (got < C_SZ && cyc < 200) begin
      out_rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (stalled) begin
        check({tag, "_hold_val"}, 32'(out_val), 32'd1);
        check({tag, "_hold_data"}, 32'(out_data), 32'(held));
      end
      if (out_val && out_rdy) begin
        check({tag, "_data"}, 32'(out_data), 32'(exp[got]));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = out_val;
        held    = out_data;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) dn++;
    end
    out_rdy = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(C_SZ));
    check({tag, "_done_pulses"}, 32'(dn), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_oval"}, 32'(out_val), 32'd0);
    check({tag, "_idle_xrdy"}, 32'(Xin_rdy), 32'd1);
    check({tag, "_idle_yrdy"}, 32'(Yin_rdy), 32'd1);
  endtask

  logic [IN_LEN-1:0]  ones[A_SZ], m8[A_SZ], rowv[A_SZ];
  logic [OUT_LEN-1:0] e4[C_SZ], e8[C_SZ], erow[C_SZ], esat[C_SZ];

  initial begin
    for (int i = 0; i < int'(A_SZ); i++) begin
      ones[i] = 4'h1;
      m8[i]   = 4'h8;
      rowv[i] = IN_LEN'(i / int'(N) + 1);
    end
    for (int i = 0; i < int'(C_SZ); i++) begin
      e4[i]   = 8'h04;
      e8[i]   = 8'h08;
      // Row r of A holds r+1, B all ones: each C element is 4*(r+1).
      erow[i] = OUT_LEN'(4 * (i / int'(Y) + 1));
`ifdef RSA_SAT_EN
      esat[i] = 8'h7F;
`else
      esat[i] = 8'h00;
`endif
    end

    sys_rst  = 1'b1;
    Xin_val  = 1'b0;
    Yin_val  = 1'b0;
    Xin_data = '0;
    Yin_data = '0;
    SA_start = 1'b0;
    SA_acc   = 1'b0;
    out_rdy  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_xrdy", 32'(Xin_rdy), 32'd0);
    check("rst_yrdy", 32'(Yin_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_oval", 32'(out_val), 32'd0);
    check("rst_odata", 32'(out_data), 32'd0);
    sys_rst = 1'b0;
    @(posedge clk); #1;
    check("rel_xrdy", 32'(Xin_rdy), 32'd1);
    check("rel_yrdy", 32'(Yin_rdy), 32'd1);

    // Ones times ones, then accumulate a second product on top.
    load(ones, ones, 1'b1, 1'b1);
    run(1'b0, 1'b0, e4, "ones");
    load(ones, ones, 1'b1, 1'b1);
    run(1'b1, 1'b0, e8, "accum");

    // Back-pressure, then distinct per-row values to check order.
    load(ones, ones, 1'b1, 1'b1);
    run(1'b0, 1'b1, e4, "stall");
    load(rowv, ones, 1'b1, 1'b1);
    run(1'b0, 1'b1, erow, "rows");

    // -8 * -8 summed four times gives 256.
    load(m8, m8, 1'b1, 1'b1);
    run(1'b0, 1'b0, esat, "neg8");

    // Start with only A present must be ignored; B arriving later completes it.
    load(ones, ones, 1'b1, 1'b0);
    SA_start = 1'b1;
    @(posedge clk); #1;
    SA_start = 1'b0;
    check("partial_busy", 32'(busy), 32'd0);
    check("partial_yrdy", 32'(Yin_rdy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("partial_busy_later", 32'(busy), 32'd0);
    check("partial_oval", 32'(out_val), 32'd0);
    load(ones, ones, 1'b0, 1'b1);
    run(1'b0, 1'b0, e4, "late_b");

    // Reset in the middle of a compute, then rerun (prior result counts as 0).
    load(ones, ones, 1'b1, 1'b1);
    SA_start = 1'b1;
    @(posedge clk); #1;
    SA_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_xrdy", 32'(Xin_rdy), 32'd0);
    check("abort_yrdy", 32'(Yin_rdy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_oval", 32'(out_val), 32'd0);
    check("abort_odata", 32'(out_data), 32'd0);
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(posedge clk); #1;
    check("abort_rel_xrdy", 32'(Xin_rdy), 32'd1);
    load(ones, ones, 1'b1, 1'b1);
    run(1'b1, 1'b0, e4, "rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_tile_engine.md
RSA_TILE_ENGINE -- requirements
Module: rsa_tile_engine

Interface
REQ-001 The block SHALL have parameter X, default 3: rows of matrix A and of result C.
REQ-002 The block SHALL have parameter N, default 4: inner dimension, the columns of A and rows of B.
REQ-003 The block SHALL have parameter Y, default 3: columns of B and of C, and the number of MAC lanes.
REQ-004 The block SHALL have parameter IN_LEN, default 4: signed operand width.
REQ-005 The block SHALL have parameter OUT_LEN, default 8: signed result width.
REQ-006 The block SHALL have parameter ADDR_WIDTH, default 4: buffer index width, at least clog2(max(X*N, N*Y, X*Y)).
REQ-007 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 The block SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have ports Xin_val in 1, Xin_rdy out 1, Xin_data in IN_LEN: stream of A, row-major.
REQ-010 The block SHALL have ports Yin_val in 1, Yin_rdy out 1, Yin_data in IN_LEN: stream of B, row-major.
REQ-011 The block SHALL have ports SA_start in 1 (launch compute) and SA_acc in 1 (accumulate mode, sampled with SA_start).
REQ-012 The block SHALL have ports busy out 1 (COMPUTE or DRAIN) and done out 1 (single-cycle compute-complete pulse).
REQ-013 The block SHALL have ports out_val out 1, out_rdy in 1, out_data out OUT_LEN: stream of C, row-major.

Function
REQ-014 The state machine SHALL have states IDLE, COMPUTE and DRAIN.
REQ-015 In IDLE, an element SHALL be accepted on each edge where val&rdy; the X and Y streams are independent.
REQ-016 Xin_rdy SHALL deassert once X*N elements are held, and Yin_rdy once N*Y elements are held.
REQ-017 Both rdy outputs SHALL be 0 outside IDLE.
REQ-018 SA_start SHALL be accepted only in IDLE with both buffers full; IDLE->COMPUTE occurs on the accepting edge, and SA_start is ignored otherwise.
REQ-019 COMPUTE SHALL last exactly X*N cycles, with Y lanes each doing one signed IN_LENxIN_LEN multiply-add per cycle (k inner, row outer).
REQ-020 Each lane's accumulator SHALL be seeded with 0, or with the prior C element when SA_acc=1.
REQ-021 Products SHALL be 2*IN_LEN bits and sums SHALL be carried at full width (2*IN_LEN+clog2(N)+1) until final reduction to OUT_LEN.
REQ-022 Each completed row SHALL be written to the result buffer one cycle after its last k.
REQ-023 COMPUTE->DRAIN SHALL occur after the last row write, and done SHALL pulse high for that one cycle.
REQ-024 The first out_val SHALL occur exactly X*N+2 cycles after the SA_start accepting edge.
REQ-025 DRAIN SHALL present X*Y elements; each transfers on out_val&out_rdy.
REQ-026 out_data and out_val SHALL hold stable while out_val&!out_rdy.
REQ-027 After the last transfer, the block SHALL return to IDLE, clear both fill counts, and retain the result buffer for SA_acc.
REQ-028 Xin_val/Yin_val asserted outside IDLE SHALL have no effect.

Reset
REQ-029 While sys_rst is high, the block SHALL hold the state at IDLE with fill, row, k and output counters at 0.
REQ-030 While sys_rst is high, all outputs SHALL be 0: Xin_rdy, Yin_rdy, busy, done, out_val and out_data.
REQ-031 rdy SHALL rise on the first edge after release.
REQ-032 Reset mid-COMPUTE or mid-DRAIN SHALL abort with no further out_val; buffer contents are then don't-care, and the prior result is treated as 0 for SA_acc.

Configuration
REQ-033 With RSA_SAT_EN defined, reduction to OUT_LEN SHALL saturate to [-2^(OUT_LEN-1), 2^(OUT_LEN-1)-1].
REQ-034 Without RSA_SAT_EN, reduction SHALL keep the low OUT_LEN bits (two's-complement wrap).

Structure
REQ-035 Package rsa_pkg SHALL hold the state enum, default parameter constants and the reduction/saturation function.
REQ-036 Sub-module rsa_mac SHALL implement one signed MAC lane (seed, accumulate, reduce) and be instantiated Y times.

Verification (X=3,N=4,Y=3,IN_LEN=4,OUT_LEN=8)
REQ-037 Bench SHALL cover: A all 1, B all 1, SA_acc=0, out_rdy=1 -> done once, 9 outputs of 0x04, first at 14 cycles after start.
REQ-038 Bench SHALL cover: A all -8, B all -8 -> sum 256; 9 outputs 0x00 without RSA_SAT_EN, 0x7F with it.
REQ-039 Bench SHALL cover: case REQ-037 with out_rdy toggling 1/0 -> 9 in-order values, each held stable while stalled.
REQ-040 Bench SHALL cover: only A loaded, SA_start pulsed -> ignored, busy=0, Yin_rdy=1.
REQ-041 Bench SHALL cover: case REQ-037, then reload ones with SA_acc=1 -> 9 outputs of 0x08.
REQ-042 Bench SHALL cover: sys_rst pulsed mid-COMPUTE -> all outputs 0 immediately, then a full rerun of REQ-037 passes.
